// File: rtl/mem_wb_stage_pkg.sv
// Shared types for the memory/writeback boundary: data words, register
// addresses, writeback source select and load funct3 encodings.
package mem_wb_stage_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  reg_addr_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic      valid;
        logic      reg_write;
        reg_addr_t rd;
        wb_sel_t   wb_sel;
        logic [2:0] funct3;
        word_t     alu_result;
        word_t     read_data;
        word_t     pc_plus4;
        word_t     imm;
    } wb_entry_t;

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// Picks the addressed byte/halfword out of an aligned memory word and
// sign- or zero-extends it; flags halfword/word accesses that are misaligned.
module mem_wb_stage_load_extend
    import mem_wb_stage_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] offset,
    input  word_t      raw,
    output word_t      data,
    output logic       misaligned
);

    logic [7:0]  byte_lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = raw[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = byte_lane[offset];
    assign sel_half = offset[1] ? raw[31:16] : raw[15:0];

    always_comb begin
        data       = raw;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  data = {{24{sel_byte[7]}}, sel_byte};
            F3_LBU: data = {24'd0, sel_byte};
            F3_LH: begin
                data       = {{16{sel_half[15]}}, sel_half};
                misaligned = offset[0];
            end
            F3_LHU: begin
                data       = {16'd0, sel_half};
                misaligned = offset[0];
            end
            // LW and any unrecognised funct3 behave as a full-word load
            default: begin
                data       = raw;
                misaligned = (offset != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register plus writeback mux, register-file write port,
// retired-instruction counter and misaligned-load flag.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_valid,
    input  logic                 mem_reg_write,
    input  reg_addr_t            mem_rd,
    input  wb_sel_t              mem_wb_sel,
    input  logic [2:0]           mem_funct3,
    input  word_t                mem_alu_result,
    input  word_t                mem_read_data,
    input  word_t                mem_pc_plus4,
    input  word_t                mem_imm,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 wb_write_enable,
    output reg_addr_t            wb_write_reg,
    output word_t                wb_write_data,
    output logic                 wb_valid,
    output logic                 wb_misaligned,
    output logic [INSTRET_W-1:0] instret
);

    wb_entry_t             entry_reg;
    logic                  committed_reg;
    logic [INSTRET_W-1:0]  instret_reg;

    word_t load_data;
    logic  load_misaligned;
    word_t mux_data;
    logic  retire;

    mem_wb_stage_load_extend u_load_extend (
        .funct3     (entry_reg.funct3),
        .offset     (entry_reg.alu_result[1:0]),
        .raw        (entry_reg.read_data),
        .data       (load_data),
        .misaligned (load_misaligned)
    );

    always_comb begin
        mux_data = entry_reg.alu_result;
        case (entry_reg.wb_sel)
            WB_ALU:  mux_data = entry_reg.alu_result;
            WB_MEM:  mux_data = load_data;
            WB_PC4:  mux_data = entry_reg.pc_plus4;
            WB_IMM:  mux_data = entry_reg.imm;
            default: mux_data = entry_reg.alu_result;
        endcase
    end

    // committed marks an entry already written/counted, so a stall only shows it
    assign wb_misaligned   = entry_reg.valid && (entry_reg.wb_sel == WB_MEM)
                             && load_misaligned && !committed_reg;
    assign retire          = entry_reg.valid && !committed_reg && !wb_misaligned;
    assign wb_write_enable = retire && entry_reg.reg_write && (entry_reg.rd != 5'd0);
    assign wb_valid        = entry_reg.valid;
    assign wb_write_reg    = entry_reg.valid ? entry_reg.rd : 5'd0;
    assign wb_write_data   = entry_reg.valid ? mux_data : 32'd0;
    assign instret         = instret_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_reg     <= '0;
            committed_reg <= 1'b0;
            instret_reg   <= '0;
        end else begin
            if (retire) begin
                instret_reg <= instret_reg + INSTRET_W'(1);
            end
            if (flush) begin
                entry_reg.valid <= 1'b0;
                committed_reg   <= 1'b0;
            end else if (stall) begin
                committed_reg <= committed_reg | entry_reg.valid;
            end else begin
                entry_reg.valid      <= mem_valid;
                entry_reg.reg_write  <= mem_reg_write;
                entry_reg.rd         <= mem_rd;
                entry_reg.wb_sel     <= mem_wb_sel;
                entry_reg.funct3     <= mem_funct3;
                entry_reg.alu_result <= mem_alu_result;
                entry_reg.read_data  <= mem_read_data;
                entry_reg.pc_plus4   <= mem_pc_plus4;
                entry_reg.imm        <= mem_imm;
                committed_reg        <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Pipeline register and writeback logic between the memory stage and the register file. Captures the MEM-stage result and control bundle on each clock, extracts and sign/zero-extends load data, selects the writeback source and drives the register-file write port (also the forwarding source for EX). Maintains a retired-instruction counter and flags misaligned loads.

## Interface
Parameters:
- INSTRET_W, 64, width of retired-instruction counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- mem_valid  input  1  MEM stage holds a real instruction (0 = bubble)
- mem_reg_write  input  1  instruction writes rd
- mem_rd  input  reg_addr_t  destination register
- mem_wb_sel  input  wb_sel_t  writeback source: WB_ALU, WB_MEM, WB_PC4, WB_IMM
- mem_funct3  input  3  load width/sign (LB 000, LH 001, LW 010, LBU 100, LHU 101)
- mem_alu_result  input  word_t  ALU result; for loads, the byte address
- mem_read_data  input  word_t  raw aligned 32-bit word from data memory
- mem_pc_plus4  input  word_t  PC+4 (JAL/JALR link)
- mem_imm  input  word_t  immediate (LUI)
- stall  input  1  hold current WB entry
- flush  input  1  kill entry loaded at next edge
- wb_write_enable  output  1  register-file write enable
- wb_write_reg  output  reg_addr_t  register-file rd
- wb_write_data  output  word_t  register-file write data
- wb_valid  output  1  WB entry is a real instruction
- wb_misaligned  output  1  current entry is a misaligned load (one-cycle flag)
- instret  output  INSTRET_W  retired-instruction count

## Operation
- Entry register: valid, reg_write, rd, wb_sel, funct3, alu_result, read_data, pc_plus4, imm, plus internal committed bit.
- Edge update priority: rst > flush > stall > load.
  - flush: valid←0, committed←0; other fields don't-care.
  - stall (no flush): all fields hold; committed←1 if valid.
  - otherwise: load all fields from mem_*, committed←0.
- Load extraction (combinational from entry), off = alu_result[1:0]:
  - LB/LBU: byte off, sign/zero-extend to 32.
  - LH/LHU: halfword at off[1]; misaligned if off[0]=1.
  - LW: whole word; misaligned if off≠0.
  - Other funct3: treated as LW.
- wb_write_data: mux by wb_sel (ALU result, extracted load, pc_plus4, imm).
- wb_misaligned = valid & wb_sel==WB_MEM & misaligned & !committed.
- wb_write_enable = valid & reg_write & (rd≠0) & !committed & !wb_misaligned.
- wb_write_reg = rd, wb_write_data driven whenever valid (usable for forwarding while stalled).
- instret increments by 1 on each edge where valid & !committed & !wb_misaligned; wraps modulo 2^INSTRET_W.

## Timing
- Latency: MEM inputs at edge N → write port valid during cycle N..N+1 → register file updated at edge N+1.
- Write enable and instret increment occur exactly once per entry, in the first cycle it is present; a stalled entry stays visible but does not rewrite or recount.
- flush and stall together: flush wins.
- rd=0 entry retires (counts) but never asserts write enable.
- Reset (async, any time, including mid-stall): valid=0, committed=0, instret=0; all outputs 0 while rst high and until first load.

## Structure
- types_pkg additions: wb_sel_t (2-bit enum), load funct3 constants (F3_LB…F3_LHU); reuse word_t, reg_addr_t.
- One sub-module natural: load_extend (funct3, offset, raw word → extended data, misaligned). Combinational.

## Test plan
- After reset: LW x5, addr 0x100, raw 0xDEADBEEF → one cycle later enable=1, reg=5, data=0xDEADBEEF; instret=1 after next edge.
- LB addr 0x103, raw 0x80FF_0000 → data 0xFFFFFF80; LBU same → 0x00000080; LHU addr 0x102 → 0x000080FF.
- LW addr 0x102 → wb_misaligned=1 for one cycle, enable=0, instret unchanged.
- ALU op to x7 then stall held 3 cycles → enable high only first cycle, data stays 0x…, instret +1 total.
- Write to x0 (WB_PC4) → enable=0, instret +1; flush with stall on same edge → next cycle valid=0, enable=0.
- Assert rst mid-stall with instret=10 → all outputs 0 immediately, instret=0.
